// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The slave modport is the loader side; master is the host/memory side.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: header count, little-endian word assembly, core hold.
// Optional trailing XOR checksum byte is enabled with `define IMEM_LOADER_CKSUM_EN.
module imem_loader #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
   parameter int unsigned       MAX_WORDS = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         done,
   output logic         err
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM,
`endif
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_lo_q, cnt_lo_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   word_idx_q, word_idx_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [23:0]        shift_q, shift_d;
   logic               in_ready_q, in_ready_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               cpu_hold_d, done_d, err_d;

   logic               accept_c;
   logic               clear_c;
   logic [CNT_W-1:0]   hdr_count_c;

   assign accept_c    = bus.in_valid && in_ready_q;
   assign clear_c     = (state_q == S_IDLE) || ((state_q == S_DONE) && start);
   assign hdr_count_c = {bus.in_data, cnt_lo_q};

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0] csum_q, csum_d;

   // Running XOR over every header and data byte accepted in this load.
   always_comb begin
      csum_d = csum_q;
      if (clear_c) begin
         csum_d = '0;
      end else if (accept_c && ((state_q == S_HDR0) || (state_q == S_HDR1) ||
                                (state_q == S_DATA))) begin
         csum_d = csum_q ^ bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) csum_q <= '0;
      else        csum_q <= csum_d;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state, counters and next values of all registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_lo_d    = cnt_lo_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err;

      if (clear_c) begin
         cnt_lo_d   = '0;
         count_d    = '0;
         word_idx_d = '0;
         byte_cnt_d = '0;
         shift_d    = '0;
         err_d      = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_HDR0;
         end
         S_HDR0: begin
            if (accept_c) begin
               cnt_lo_d = bus.in_data;
               state_d  = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept_c) begin
               count_d = hdr_count_c;
               if (hdr_count_c == '0) begin
                  state_d = S_DONE;
               end else if (32'(hdr_count_c) > MAX_WORDS) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept_c) begin
               shift_d    = {bus.in_data, shift_q[23:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = {bus.in_data, shift_q};
                  mem_addr_d  = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
                  word_idx_d  = word_idx_q + CNT_W'(1);
                  if (word_idx_q == (count_q - CNT_W'(1))) begin
`ifdef IMEM_LOADER_CKSUM_EN
                     state_d = S_CKSUM;
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef IMEM_LOADER_CKSUM_EN
         S_CKSUM: begin
            if (accept_c) begin
               err_d   = (bus.in_data != csum_q);
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (start) state_d = S_HDR0;
         end
         default: state_d = S_IDLE;
      endcase

      // Level outputs follow the state being entered, so they change with it.
      in_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CKSUM_EN
      in_ready_d = in_ready_d || (state_d == S_CKSUM);
`endif
      done_d     = (state_d == S_DONE);
      cpu_hold_d = (state_d != S_DONE);
   end

   // Datapath and output registers; reset drops any in-flight write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_lo_q    <= '0;
         count_q     <= '0;
         word_idx_q  <= '0;
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold    <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         cnt_lo_q    <= cnt_lo_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold    <= cpu_hold_d;
         done        <= done_d;
         err         <= err_d;
      end
   end

endmodule
